instr_mem_ctrl: RTL and testbench
=================================

Name: instr_mem_ctrl

Overview:
Parametrised instruction memory with a valid/ready fetch port, a program (boot-load) write port, and a post-reset clear sweep. Sits between the PC/fetch stage and the core pipeline. Replaces the fixed 64-word, combinational-read, hard-coded-contents memory. Adds registered single-cycle-latency reads, back-pressure, and address-fault reporting.

Parameters:
DATA_W, 32, instruction width in bits
DEPTH, 64, number of words; any value >= 2
ADDR_W, 32, byte-address width on both ports
CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = contents retained and the block is ready immediately
FAULT_INSTR, 32'h00000013, word returned on a faulted fetch (RISC-V NOP, addi x0,x0,0)

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  asynchronous, active-high
prog_en  in  1  program mode; blocks fetch while high
prog_we  in  1  write strobe; honoured only when prog_en=1
prog_addr  in  ADDR_W  byte address of the program write
prog_wdata  in  DATA_W  program write data
prog_err  out  1  one-cycle pulse: program write dropped (misaligned or out of range)
fetch_req_valid  in  1  fetch request valid
fetch_req_ready  out  1  fetch request accepted when valid&ready
fetch_addr  in  ADDR_W  fetch byte address
fetch_rsp_valid  out  1  response valid
fetch_rsp_ready  in  1  consumer accepts the response
fetch_rsp_instr  out  DATA_W  fetched word, or FAULT_INSTR on fault
fetch_rsp_fault  out  2  bit0 = misaligned (addr[1:0]!=0); bit1 = out of range (addr>>2 >= DEPTH)
init_busy  out  1  clear sweep in progress

Behaviour:
- Reset (async, active-high) drives these outputs:
  - fetch_rsp_valid=0, fetch_rsp_instr=0, fetch_rsp_fault=0, prog_err=0.
  - init_busy=CLEAR_ON_RESET; clear pointer=0.
  - State = CLEAR if CLEAR_ON_RESET, else RUN.
- Reset asserted mid-sweep or mid-transaction aborts it. Any pending response is lost. The sweep restarts from word 0 after deassertion.
- FSM state CLEAR:
  - Writes 0 to word[ptr] each cycle and increments ptr.
  - After writing word DEPTH-1, moves to RUN. init_busy is therefore high for exactly DEPTH cycles after reset deassertion.
  - fetch_req_ready=0 throughout; program writes are ignored, with no prog_err.
- FSM state RUN: there is no exit other than reset.
- Word index = addr >> 2. An index is in range iff it is < DEPTH; its width is clog2(DEPTH).
- Program write: occurs in RUN when prog_en&prog_we and the address is aligned and in range. The write lands at the clock edge.
  - A misaligned or out-of-range write is dropped, and prog_err pulses on the next cycle.
- fetch_req_ready = (state==RUN) & !prog_en & (!fetch_rsp_valid | fetch_rsp_ready).
- Read latency: a request accepted at edge N has its response visible after edge N, i.e. 1 cycle.
  - Full-throughput streaming is possible: one request per cycle when fetch_rsp_ready stays 1.
- Response register:
  - Loaded on acceptance.
  - Held stable (instr, fault, valid) while fetch_rsp_valid & !fetch_rsp_ready.
  - Cleared (valid=0) on the handshake edge if no new request is accepted in the same cycle.
- Fault response: fetch_rsp_instr=FAULT_INSTR and the fault bits are set. Both bits can be set at once. Memory is not read.
- Same-cycle program write and read of the same word cannot occur, because prog_en blocks fetch. A read issued the cycle after a write returns the new data.
- Raising prog_en while a response is pending does not disturb that response.
- Address bits above the index are not aliased. Any set bit that makes the index >= DEPTH is a fault.

Decomposition:
- Package instr_mem_pkg holds:
  - fault-code constants FAULT_NONE=2'b00, FAULT_MISALIGN=2'b01, FAULT_RANGE=2'b10;
  - FSM state enum {S_CLEAR, S_RUN};
  - NOP constant 32'h00000013.
- One sub-module: imem_ram, a single-port synchronous RAM with one write port and registered read, parametrised by DATA_W/DEPTH. The controller muxes the write address/data among clear, program and none.

Test Plan:
- CLEAR_ON_RESET=1, DEPTH=64: release reset -> init_busy high exactly 64 cycles, fetch_req_ready=0 throughout; then fetch addr 0x0C -> instr 0, fault 0.
- Program words 0..5 = 3,6,9,12,15,18 via prog_en/prog_we, drop prog_en, stream fetches 0x00..0x14 with rsp_ready=1 -> one response per cycle, 1-cycle latency, values 3..18 in order.
- Fetch 0x02 -> fault=01, instr=0x00000013; fetch 0x100 (index 64) -> fault=10; fetch 0x102 -> fault=11.
- Back-pressure: hold fetch_rsp_ready=0 for 3 cycles after a response to 0x04 (data 6) -> fetch_rsp_valid/instr held at 6, fetch_req_ready=0; release -> next request accepted the same cycle.
- Program write to 0x101 -> prog_err pulses 1 cycle, memory unchanged. Write during CLEAR -> ignored, no prog_err.
- Assert reset mid-sweep at cycle 20 -> outputs return to reset values; after release the sweep runs a full 64 cycles. CLEAR_ON_RESET=0 -> ready the cycle after reset, previously programmed data retained.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared constants and types for the instruction memory controller
package instr_mem_pkg;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

endpackage

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - single-port synchronous RAM, one write port and a registered read
module imem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // The array itself has no reset so contents can survive a reset pulse.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/instr_mem_ctrl.sv
// rtl/instr_mem_ctrl.sv - instruction memory with valid/ready fetch, boot-load port and clear sweep
module instr_mem_ctrl
  import instr_mem_pkg::*;
#(
  parameter int                DATA_W         = 32,
  parameter int                DEPTH          = 64,
  parameter int                ADDR_W         = 32,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] FAULT_INSTR    = DATA_W'(NOP_INSTR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_en,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_wdata,
  output logic              prog_err,
  input  logic              fetch_req_valid,
  output logic              fetch_req_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_rsp_valid,
  input  logic              fetch_rsp_ready,
  output logic [DATA_W-1:0] fetch_rsp_instr,
  output logic [1:0]        fetch_rsp_fault,
  output logic              init_busy
);

  localparam int IDX_W = $clog2(DEPTH);

  function automatic logic [1:0] addr_fault(input logic [ADDR_W-1:0] a);
    logic [1:0] f;
    f = FAULT_NONE;
    if (a[1:0] != 2'b00) f = f | FAULT_MISALIGN;
    // Full-width compare: any high bit set is a range fault, never an alias.
    if ((a >> 2) >= ADDR_W'(DEPTH)) f = f | FAULT_RANGE;
    return f;
  endfunction

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [1:0]        rsp_fault;
  logic [1:0]        fetch_fault;
  logic [1:0]        prog_fault;
  logic              clearing;
  logic              accept;
  logic              prog_ok;
  logic              prog_drop;
  logic              ram_we;
  logic              ram_re;
  logic [IDX_W-1:0]  ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  always_comb begin
    clearing        = (state == S_CLEAR);
    fetch_fault     = addr_fault(fetch_addr);
    prog_fault      = addr_fault(prog_addr);
    fetch_req_ready = (state == S_RUN) && !prog_en && (!fetch_rsp_valid || fetch_rsp_ready);
    accept          = fetch_req_valid && fetch_req_ready;
    prog_ok         = (state == S_RUN) && prog_en && prog_we && (prog_fault == FAULT_NONE);
    prog_drop       = (state == S_RUN) && prog_en && prog_we && (prog_fault != FAULT_NONE);
    ram_we          = clearing || prog_ok;
    ram_re          = accept && (fetch_fault == FAULT_NONE);
    ram_wdata       = clearing ? '0 : prog_wdata;
    // Clear, program and fetch never need the port in the same cycle.
    if (clearing)     ram_addr = ptr;
    else if (prog_en) ram_addr = prog_addr[IDX_W+1:2];
    else              ram_addr = fetch_addr[IDX_W+1:2];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
      ptr             <= '0;
      fetch_rsp_valid <= 1'b0;
      rsp_fault       <= FAULT_NONE;
      prog_err        <= 1'b0;
    end else begin
      prog_err <= prog_drop;
      if (clearing) begin
        ptr <= ptr + IDX_W'(1);
        if (ptr == IDX_W'(DEPTH - 1)) state <= S_RUN;
      end
      if (accept) begin
        fetch_rsp_valid <= 1'b1;
        rsp_fault       <= fetch_fault;
      end else if (fetch_rsp_ready) begin
        fetch_rsp_valid <= 1'b0;
      end
    end
  end

  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // The RAM read register only updates on a clean fetch, so it holds under back-pressure.
  assign fetch_rsp_instr = (rsp_fault != FAULT_NONE) ? FAULT_INSTR : ram_rdata;
  assign fetch_rsp_fault = rsp_fault;
  assign init_busy       = clearing;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// tb/tb_instr_mem_ctrl.sv - scoreboard bench for instr_mem_ctrl
module tb_instr_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        prog_en = 1'b0, prog_we = 1'b0;
  logic [31:0] prog_addr = '0, prog_wdata = '0;
  logic        prog_err;
  logic        fetch_req_valid = 1'b0, fetch_req_ready;
  logic [31:0] fetch_addr = '0;
  logic        fetch_rsp_valid, fetch_rsp_ready = 1'b1;
  logic [31:0] fetch_rsp_instr;
  logic [1:0]  fetch_rsp_fault;
  logic        init_busy;

  logic        b_reset = 1'b1;
  logic        b_prog_en = 1'b0, b_prog_we = 1'b0;
  logic [31:0] b_prog_addr = '0, b_prog_wdata = '0;
  logic        b_prog_err;
  logic        b_req_valid = 1'b0, b_req_ready;
  logic [31:0] b_fetch_addr = '0;
  logic        b_rsp_valid, b_rsp_ready = 1'b1;
  logic [31:0] b_rsp_instr;
  logic [1:0]  b_rsp_fault;
  logic        b_init_busy;

  int          total = 0;
  int          bad = 0;
  logic [31:0] mdl [64];
  logic [63:0] sb [$];
  bit          acc_prev = 1'b0;

  always #5 clk = ~clk;

  instr_mem_ctrl dut (
    .clk(clk), .reset(reset),
    .prog_en(prog_en), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .prog_err(prog_err),
    .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready), .fetch_addr(fetch_addr),
    .fetch_rsp_valid(fetch_rsp_valid), .fetch_rsp_ready(fetch_rsp_ready),
    .fetch_rsp_instr(fetch_rsp_instr), .fetch_rsp_fault(fetch_rsp_fault),
    .init_busy(init_busy)
  );

  instr_mem_ctrl #(.CLEAR_ON_RESET(1'b0)) dut_keep (
    .clk(clk), .reset(b_reset),
    .prog_en(b_prog_en), .prog_we(b_prog_we), .prog_addr(b_prog_addr), .prog_wdata(b_prog_wdata),
    .prog_err(b_prog_err),
    .fetch_req_valid(b_req_valid), .fetch_req_ready(b_req_ready), .fetch_addr(b_fetch_addr),
    .fetch_rsp_valid(b_rsp_valid), .fetch_rsp_ready(b_rsp_ready),
    .fetch_rsp_instr(b_rsp_instr), .fetch_rsp_fault(b_rsp_fault),
    .init_busy(b_init_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] tb_fault(input logic [31:0] a);
    return {(a >> 2) >= 32'd64, a[1:0] != 2'b00};
  endfunction

  function automatic logic [63:0] exp_rsp(input logic [31:0] a);
    logic [1:0] f;
    f = tb_fault(a);
    return {30'b0, f, (f != 2'b00) ? 32'h00000013 : mdl[a[7:2]]};
  endfunction

  // Scoreboard: push on request handshake, pop on response handshake.
  always @(negedge clk) begin
    if (reset) begin
      acc_prev = 1'b0;
    end else begin
      if (acc_prev) check("latency", {63'b0, fetch_rsp_valid}, 64'd1);
      if (fetch_rsp_valid && fetch_rsp_ready) begin
        if (sb.size() == 0) check("sb_depth", 64'(sb.size()), 64'd1);
        else check("rsp", {30'b0, fetch_rsp_fault, fetch_rsp_instr}, sb.pop_front());
      end
      acc_prev = fetch_req_valid && fetch_req_ready;
      if (acc_prev) sb.push_back(exp_rsp(fetch_addr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rvalid"}, {63'b0, fetch_rsp_valid}, 64'd0);
    check({tag, "_instr"}, {32'b0, fetch_rsp_instr}, 64'd0);
    check({tag, "_fault"}, {62'b0, fetch_rsp_fault}, 64'd0);
    check({tag, "_perr"}, {63'b0, prog_err}, 64'd0);
    check({tag, "_busy"}, {63'b0, init_busy}, 64'd1);
    check({tag, "_rdy"}, {63'b0, fetch_req_ready}, 64'd0);
  endtask

  task automatic sweep_check(input bit try_write);
    int n = 0;
    int guard = 0;
    @(negedge clk);
    while (init_busy && guard < 200) begin
      n++;
      guard++;
      check("clr_rdy", {63'b0, fetch_req_ready}, 64'd0);
      check("clr_perr", {63'b0, prog_err}, 64'd0);
      if (try_write && n == 8) begin
        prog_en = 1'b1; prog_we = 1'b1; prog_addr = 32'h0C; prog_wdata = 32'hDEADBEEF;
      end
      if (n == 10) begin
        prog_en = 1'b0; prog_we = 1'b0;
      end
      @(negedge clk);
    end
    prog_en = 1'b0; prog_we = 1'b0;
    check("busy_cycles", 64'(n), 64'd64);
    for (int i = 0; i < 64; i++) mdl[i] = '0;
  endtask

  task automatic fetch(input logic [31:0] a);
    int guard = 0;
    fetch_req_valid = 1'b1;
    fetch_addr = a;
    @(negedge clk);
    while (!fetch_req_ready && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    check("fetch_rdy", {63'b0, fetch_req_ready}, 64'd1);
    tick();
    fetch_req_valid = 1'b0;
  endtask

  task automatic prog(input logic [31:0] a, input logic [31:0] d);
    bit legal;
    legal = (tb_fault(a) == 2'b00);
    prog_en = 1'b1; prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    tick();
    prog_en = 1'b0; prog_we = 1'b0;
    if (legal) mdl[a[7:2]] = d;
    @(negedge clk);
    check("perr", {63'b0, prog_err}, {63'b0, !legal});
    @(negedge clk);
    check("perr_pulse", {63'b0, prog_err}, 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mdl[i] = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");

    // Retaining variant: ready straight out of reset, contents survive a reset pulse.
    tick();
    b_reset = 1'b0;
    @(negedge clk);
    check("keep_rdy", {63'b0, b_req_ready}, 64'd1);
    check("keep_busy", {63'b0, b_init_busy}, 64'd0);
    tick();
    b_prog_en = 1'b1; b_prog_we = 1'b1; b_prog_addr = 32'h0C; b_prog_wdata = 32'hABCD0123;
    tick();
    b_prog_en = 1'b0; b_prog_we = 1'b0;
    b_reset = 1'b1;
    tick();
    b_reset = 1'b0;
    @(negedge clk);
    check("keep_rdy2", {63'b0, b_req_ready}, 64'd1);
    tick();
    b_req_valid = 1'b1; b_fetch_addr = 32'h0C;
    tick();
    b_req_valid = 1'b0;
    @(negedge clk);
    check("keep_valid", {63'b0, b_rsp_valid}, 64'd1);
    check("keep_data", {32'b0, b_rsp_instr}, 64'hABCD0123);

    tick();
    reset = 1'b0;
    sweep_check(1'b1);
    tick();
    fetch(32'h0C);
    repeat (2) tick();

    for (int i = 0; i < 6; i++) prog(32'(i * 4), 32'(3 * (i + 1)));
    prog(32'h101, 32'h55555555);

    fetch_req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      fetch_addr = 32'(i * 4);
      @(negedge clk);
      check("stream_rdy", {63'b0, fetch_req_ready}, 64'd1);
      tick();
    end
    fetch_req_valid = 1'b0;
    repeat (2) tick();

    fetch(32'h02);
    fetch(32'h100);
    fetch(32'h102);
    fetch(32'h80000000);
    fetch(32'h00);
    repeat (2) tick();

    fetch_rsp_ready = 1'b0;
    fetch(32'h04);
    fetch_req_valid = 1'b1;
    fetch_addr = 32'h08;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", {63'b0, fetch_rsp_valid}, 64'd1);
      check("bp_instr", {32'b0, fetch_rsp_instr}, 64'd6);
      check("bp_rdy", {63'b0, fetch_req_ready}, 64'd0);
      tick();
    end
    prog_en = 1'b1;
    @(negedge clk);
    check("bp_prog_hold", {32'b0, fetch_rsp_instr}, 64'd6);
    tick();
    prog_en = 1'b0;
    fetch_rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_rdy", {63'b0, fetch_req_ready}, 64'd1);
    tick();
    fetch_req_valid = 1'b0;
    repeat (3) tick();
    check("sb_left", 64'(sb.size()), 64'd0);

    reset = 1'b1;
    sb.delete();
    tick();
    reset = 1'b0;
    repeat (20) @(negedge clk);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    tick();
    reset = 1'b0;
    sweep_check(1'b0);
    tick();
    fetch(32'h04);
    repeat (2) tick();
    check("sb_final", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
